// File: rtl/xalu_ctrl.sv
// xalu_ctrl: sequencer for the multiply/divide unit and owner of the HI/LO
// registers. Multiplies complete after a fixed MUL_CYCLES busy cycles; divides
// run a 32-iteration restoring loop plus one sign-fixup cycle.
module xalu_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  state_t      state_r, state_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        done_r, done_nxt_s;
  logic [31:0] hi_r, hi_nxt_s;
  logic [31:0] lo_r, lo_nxt_s;
  logic [4:0]  cnt_r, cnt_nxt_s;
  logic [31:0] opa_r, opa_nxt_s;   // raw src_a (multiplicand, or dividend for div-by-zero HI)
  logic [31:0] opb_r, opb_nxt_s;   // raw src_b for multiply, |src_b| for divide
  logic        sgn_r, sgn_nxt_s;   // signed multiply
  logic        sa_r, sa_nxt_s;     // dividend sign
  logic        sb_r, sb_nxt_s;     // divisor sign
  logic        dvz_r, dvz_nxt_s;   // divisor was zero
  logic [31:0] rem_r, rem_nxt_s;   // partial remainder
  logic [31:0] quo_r, quo_nxt_s;   // dividend shifting out / quotient shifting in

  logic        accept_s;
  logic        op_signed_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [63:0] prod_s;
  logic [32:0] shift_s;
  logic [32:0] diff_s;

  // Next-state, datapath and HI/LO update logic for the sequencer.
  always_comb begin
    state_nxt_s = state_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    cnt_nxt_s   = cnt_r;
    opa_nxt_s   = opa_r;
    opb_nxt_s   = opb_r;
    sgn_nxt_s   = sgn_r;
    sa_nxt_s    = sa_r;
    sb_nxt_s    = sb_r;
    dvz_nxt_s   = dvz_r;
    rem_nxt_s   = rem_r;
    quo_nxt_s   = quo_r;

    accept_s    = op_valid & ~flush & ~busy_r & (op <= 3'd5);
    // MULT and DIV have op[0] clear; MULTU and DIVU have it set.
    op_signed_s = ~op[0];
    abs_a_s     = (op_signed_s & src_a[31]) ? (32'd0 - src_a) : src_a;
    abs_b_s     = (op_signed_s & src_b[31]) ? (32'd0 - src_b) : src_b;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // the correct two's-complement result either way.
    prod_s  = {{32{sgn_r & opa_r[31]}}, opa_r} * {{32{sgn_r & opb_r[31]}}, opb_r};
    shift_s = {rem_r, quo_r[31]};
    diff_s  = shift_s - {1'b0, opb_r};

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (op)
            3'd0, 3'd1: begin
              state_nxt_s = ST_MUL;
              busy_nxt_s  = 1'b1;
              cnt_nxt_s   = 5'd0;
              opa_nxt_s   = src_a;
              opb_nxt_s   = src_b;
              sgn_nxt_s   = op_signed_s;
            end
            3'd2, 3'd3: begin
              state_nxt_s = ST_DIV;
              busy_nxt_s  = 1'b1;
              cnt_nxt_s   = 5'd0;
              opa_nxt_s   = src_a;
              opb_nxt_s   = abs_b_s;
              quo_nxt_s   = abs_a_s;
              rem_nxt_s   = 32'd0;
              sa_nxt_s    = op_signed_s & src_a[31];
              sb_nxt_s    = op_signed_s & src_b[31];
              dvz_nxt_s   = (src_b == 32'd0);
            end
            3'd4: begin
              hi_nxt_s = src_a;
            end
            3'd5: begin
              lo_nxt_s = src_a;
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_MUL: begin
        if (cnt_r == MUL_LAST) begin
          {hi_nxt_s, lo_nxt_s} = prod_s;
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          cnt_nxt_s   = 5'd0;
        end else begin
          cnt_nxt_s = cnt_r + 5'd1;
        end
      end

      ST_DIV: begin
        // Restoring step: keep the trial difference only if it did not borrow.
        if (diff_s[32] == 1'b0) begin
          rem_nxt_s = diff_s[31:0];
          quo_nxt_s = {quo_r[30:0], 1'b1};
        end else begin
          rem_nxt_s = shift_s[31:0];
          quo_nxt_s = {quo_r[30:0], 1'b0};
        end
        cnt_nxt_s = cnt_r + 5'd1;
        if (cnt_r == DIV_LAST) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end

      ST_FIX: begin
        if (dvz_r) begin
          lo_nxt_s = 32'hFFFF_FFFF;
          hi_nxt_s = opa_r;
        end else begin
          lo_nxt_s = (sa_r ^ sb_r) ? (32'd0 - quo_r) : quo_r;
          hi_nxt_s = sa_r ? (32'd0 - rem_r) : rem_r;
        end
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b1;
      end

      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears HI/LO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      cnt_r   <= 5'd0;
      opa_r   <= 32'd0;
      opb_r   <= 32'd0;
      sgn_r   <= 1'b0;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      dvz_r   <= 1'b0;
      rem_r   <= 32'd0;
      quo_r   <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
      cnt_r   <= cnt_nxt_s;
      opa_r   <= opa_nxt_s;
      opb_r   <= opb_nxt_s;
      sgn_r   <= sgn_nxt_s;
      sa_r    <= sa_nxt_s;
      sb_r    <= sb_nxt_s;
      dvz_r   <= dvz_nxt_s;
      rem_r   <= rem_nxt_s;
      quo_r   <= quo_nxt_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_xalu_ctrl.sv
// Scoreboard bench for xalu_ctrl: expected HI/LO and completion cycle are
// queued at issue and compared when done pulses.
module tb_xalu_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 33;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  xalu_ctrl #(.MUL_CYCLES(MUL_N)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to check completion latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural reference results for mult/div.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    logic na, nb;
    if (o == 3'd0) begin
      p = 64'(longint'($signed(a)) * longint'($signed(b)));
      {rh, rl} = p;
    end else if (o == 3'd1) begin
      p = {32'd0, a} * {32'd0, b};
      {rh, rl} = p;
    end else if (b == 32'd0) begin
      rh = a;
      rl = 32'hFFFF_FFFF;
    end else begin
      na = (o == 3'd2) && a[31];
      nb = (o == 3'd2) && b[31];
      ma = na ? (32'd0 - a) : a;
      mb = nb ? (32'd0 - b) : b;
      q = ma / mb;
      r = ma % mb;
      rl = (na ^ nb) ? (32'd0 - q) : q;
      rh = na ? (32'd0 - r) : r;
    end
  endfunction

  // Present one op for one cycle; queue expectations for mult/div.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    logic [31:0] prev_hi, prev_lo;
    logic runs;
    check_eq("issue_idle", {63'd0, busy}, 64'd0);
    prev_hi = m_hi;
    prev_lo = m_lo;
    runs = !fl && (o <= 3'd3);
    op_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    flush = fl;
    if (runs) begin
      e.hi = eh;
      e.lo = el;
      e.cyc = cyc + 1 + ((o <= 3'd1) ? MUL_N : DIV_N);
      sb_q.push_back(e);
      m_hi = eh;
      m_lo = el;
    end else if (!fl && o == 3'd4) begin
      m_hi = a;
    end else if (!fl && o == 3'd5) begin
      m_lo = a;
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    flush = 1'b0;
    op = 3'($urandom_range(0, 7));
    src_a = $urandom;
    src_b = $urandom;
    if (runs) begin
      check_eq("busy_on", {63'd0, busy}, 64'd1);
      check_eq("hi_hold", {32'd0, hi}, {32'd0, prev_hi});
      check_eq("lo_hold", {32'd0, lo}, {32'd0, prev_lo});
    end else begin
      check_eq("busy_off", {63'd0, busy}, 64'd0);
      check_eq("hi_now", {32'd0, hi}, {32'd0, m_hi});
      check_eq("lo_now", {32'd0, lo}, {32'd0, m_lo});
    end
  endtask

  // Wait (bounded) until the scoreboard drains; returns inside the done cycle.
  task automatic wait_done();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      check_eq("timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  // Completion monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("latency", 64'(cyc), 64'(mon_e.cyc));
        check_eq("done_hi", {32'd0, hi}, {32'd0, mon_e.hi});
        check_eq("done_lo", {32'd0, lo}, {32'd0, mon_e.lo});
        check_eq("done_busy", {63'd0, busy}, 64'd0);
      end
    end
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, rh, rl;

    repeat (2) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // MULT -2 * 3
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    wait_done();
    // MULTU issued back-to-back in the done cycle
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done();
    // MTHI in the done cycle overwrites the just-written HI
    issue(3'd4, 32'h0000_CAFE, 32'd0, 1'b0, 32'd0, 32'd0);

    // DIV -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done();
    // DIVU by zero
    issue(3'd3, 32'd100, 32'd0, 1'b0, 32'd100, 32'hFFFF_FFFF);
    wait_done();
    // DIV overflow
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
    wait_done();

    // DIV presented with flush is dropped
    issue(3'd2, 32'd50, 32'd7, 1'b1, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("flush_busy", {63'd0, busy}, 64'd0);
    check_eq("flush_hi", {32'd0, hi}, {32'd0, m_hi});
    check_eq("flush_lo", {32'd0, lo}, {32'd0, m_lo});
    @(posedge clk);
    #1;

    // flush mid-divide does not abort it
    issue(3'd2, 32'd1000, 32'd7, 1'b0, 32'd6, 32'd142);
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_done();

    // reset around busy cycle 10 aborts immediately
    issue(3'd3, 32'd12345, 32'd10, 1'b0, 32'd5, 32'd1234);
    repeat (9) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_hi", {32'd0, hi}, 64'd0);
    check_eq("abort_lo", {32'd0, lo}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    sb_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // MTLO with nothing in flight
    issue(3'd5, 32'h0000_1234, 32'd0, 1'b0, 32'd0, 32'd0);
    // op code 7 is ignored
    issue(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;

    // random mult/div against the reference model
    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 40)) : $urandom);
      model(ro, ra, rb, rh, rl);
      issue(ro, ra, rb, 1'b0, rh, rl);
      wait_done();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
